// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared constants and divisor type for the programmable clock divider
package clkdiv_pkg;
  localparam int MIN_DIV = 2;
  localparam int DEF_DIV_WIDTH = 8;
  typedef logic [DEF_DIV_WIDTH-1:0] div_t;
endpackage

// File: rtl/clkdiv_counter.sv
// clkdiv_counter: period counter, wrap detect and high-phase compare for clock_divider_prog
module clkdiv_counter #(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk_100mhz_in,
  input  logic                 reset_in,
  input  logic                 enable_in,
  input  logic [DIV_WIDTH-1:0] div_in,
  output logic                 wrap_out,
  output logic                 running_out,
  output logic                 clk_div_out,
  output logic                 tick_out
);
  logic [DIV_WIDTH-1:0] cnt, cnt_nxt;
  logic last;
  assign last = cnt == div_in - DIV_WIDTH'(1);
  assign wrap_out = enable_in && running_out && last;
  // first enabled edge after a stop starts a fresh period at 0
  always_comb cnt_nxt = (!running_out || last) ? '0 : cnt + DIV_WIDTH'(1);
  // advance the period and register the phase outputs from the next count
  always_ff @(posedge clk_100mhz_in or posedge reset_in)
    if (reset_in) begin
      cnt <= '0;
      running_out <= 1'b0;
      clk_div_out <= 1'b0;
      tick_out <= 1'b0;
    end else begin
      running_out <= enable_in;
      cnt <= enable_in ? cnt_nxt : '0;
      clk_div_out <= enable_in && cnt_nxt < (div_in >> 1);
      tick_out <= enable_in && cnt_nxt == '0;
    end
endmodule

// File: rtl/clock_divider_prog.sv
// clock_divider_prog: runtime-programmable glitch-free clock divider; CLKDIV_HALF_CYCLE_EN gives 50% duty for odd ratios
module clock_divider_prog import clkdiv_pkg::*; #(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                 clk_100mhz_in,
  input  logic                 reset_in,
  input  logic                 enable_in,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 div_load_in,
  output logic                 div_ack_out,
  output logic                 div_err_out,
  output logic [DIV_WIDTH-1:0] div_active_out,
  output logic                 clk_div_out,
  output logic                 tick_out
);
  logic [DIV_WIDTH-1:0] pending;
  logic pending_valid, load_ok, apply, wrap, running, clk_raw;
  assign load_ok = div_load_in && div_in >= DIV_WIDTH'(MIN_DIV);
  // a pending ratio only lands on a period boundary, or at once while stopped
  assign apply = pending_valid && (wrap || !running);
  clkdiv_counter #(.DIV_WIDTH(DIV_WIDTH)) u_counter (
    .clk_100mhz_in(clk_100mhz_in),
    .reset_in(reset_in),
    .enable_in(enable_in),
    .div_in(div_active_out),
    .wrap_out(wrap),
    .running_out(running),
    .clk_div_out(clk_raw),
    .tick_out(tick_out)
  );
  // load handshake: capture, overwrite, apply with ack, sticky error on illegal ratios
  always_ff @(posedge clk_100mhz_in or posedge reset_in)
    if (reset_in) begin
      pending <= '0;
      pending_valid <= 1'b0;
      div_active_out <= DIV_WIDTH'(DEFAULT_DIV);
      div_ack_out <= 1'b0;
      div_err_out <= 1'b0;
    end else begin
      pending <= load_ok ? div_in : pending;
      pending_valid <= load_ok || (pending_valid && !apply);
      div_active_out <= apply ? pending : div_active_out;
      div_ack_out <= apply;
      div_err_out <= div_err_out || (div_load_in && !load_ok);
    end
`ifdef CLKDIV_HALF_CYCLE_EN
  logic half_q;
  // stretch the high phase by half a source cycle when the ratio is odd
  always_ff @(negedge clk_100mhz_in or posedge reset_in)
    if (reset_in) half_q <= 1'b0;
    else half_q <= clk_raw && div_active_out[0];
  assign clk_div_out = clk_raw | half_q;
`else
  assign clk_div_out = clk_raw;
`endif
endmodule

// File: tb/tb_clock_divider_prog.sv
// tb_clock_divider_prog: vector table, reset corner cases and randomized model check for clock_divider_prog
`timescale 1ns/1ps
module tb_clock_divider_prog;
  import clkdiv_pkg::*;
  logic clk = 1'b0;
  logic reset_in, enable_in, div_load_in;
  div_t div_in;
  logic div_ack_out, div_err_out, clk_div_out, tick_out;
  div_t div_active_out;
  int n_vec = 0, n_err = 0;
  logic last_clk = 1'b0;
  div_t last_act = 8'd4;
  bit m_run, m_pv, m_err;
  int m_pos, m_n, m_pend;
  logic e_clk, e_tick, e_ack;

  typedef struct {
    logic en, ld;
    div_t din;
    logic clk, tick, ack, err;
    div_t act;
  } vec_t;
  vec_t tbl[$];

  clock_divider_prog dut (
    .clk_100mhz_in(clk),
    .reset_in(reset_in),
    .enable_in(enable_in),
    .div_in(div_in),
    .div_load_in(div_load_in),
    .div_ack_out(div_ack_out),
    .div_err_out(div_err_out),
    .div_active_out(div_active_out),
    .clk_div_out(clk_div_out),
    .tick_out(tick_out)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic eclk, etick, eack, eerr, input div_t eact);
    logic ev;
    ev = eclk;
`ifdef CLKDIV_HALF_CYCLE_EN
    ev = eclk | (last_clk & last_act[0]);
`endif
    last_clk = eclk;
    last_act = eact;
    cmp({tag, ".clk"}, 32'(clk_div_out), 32'(ev));
    cmp({tag, ".tick"}, 32'(tick_out), 32'(etick));
    cmp({tag, ".ack"}, 32'(div_ack_out), 32'(eack));
    cmp({tag, ".err"}, 32'(div_err_out), 32'(eerr));
    cmp({tag, ".act"}, 32'(div_active_out), 32'(eact));
  endtask

  task automatic step(input logic en, ld, input div_t d);
    enable_in = en;
    div_load_in = ld;
    div_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic en, ld, input div_t din, input logic c, t, a, e, input div_t act);
    vec_t v;
    v.en = en; v.ld = ld; v.din = din;
    v.clk = c; v.tick = t; v.ack = a; v.err = e; v.act = act;
    tbl.push_back(v);
  endtask

  task automatic model_reset();
    m_run = 0; m_pv = 0; m_err = 0; m_pos = 0; m_n = 4; m_pend = 0;
    last_clk = 1'b0;
    last_act = 8'd4;
  endtask

  // behavioural reference: position within a period of length m_n, ratios swap only between periods
  task automatic model_step(input bit en, ld, input int din);
    bit period_end, applied;
    period_end = en && m_run && m_pos == m_n - 1;
    applied = m_pv && (period_end || !m_run);
    if (en) m_pos = (!m_run || period_end) ? 0 : m_pos + 1;
    else m_pos = 0;
    if (applied) m_n = m_pend;
    if (ld && din >= 2) begin
      m_pend = din;
      m_pv = 1;
    end else if (applied) m_pv = 0;
    if (ld && din < 2) m_err = 1;
    m_run = en;
    e_clk = en && m_pos < m_n / 2;
    e_tick = en && m_pos == 0;
    e_ack = applied;
  endtask

  initial begin
    // ratio 4 free-running
    add(1,0,0, 1,1,0,0,4); add(1,0,0, 1,0,0,0,4); add(1,0,0, 0,0,0,0,4); add(1,0,0, 0,0,0,0,4);
    add(1,0,0, 1,1,0,0,4); add(1,0,0, 1,0,0,0,4);
    // load 5 mid-period, lands on the wrap
    add(1,1,5, 0,0,0,0,4); add(1,0,0, 0,0,0,0,4); add(1,0,0, 1,1,1,0,5); add(1,0,0, 1,0,0,0,5);
    add(1,0,0, 0,0,0,0,5); add(1,0,0, 0,0,0,0,5); add(1,0,0, 0,0,0,0,5); add(1,0,0, 1,1,0,0,5);
    // stop mid-high, load 3 while stopped, restart
    add(0,0,0, 0,0,0,0,5); add(0,1,3, 0,0,0,0,5); add(0,0,0, 0,0,1,0,3); add(1,0,0, 1,1,0,0,3);
    add(1,0,0, 0,0,0,0,3); add(1,0,0, 0,0,0,0,3); add(1,0,0, 1,1,0,0,3);
    // illegal ratios 1 and 0
    add(1,1,1, 0,0,0,1,3); add(1,1,0, 0,0,0,1,3); add(1,0,0, 1,1,0,1,3);
    // 7 then 9 before the wrap: single ack, 9 wins
    add(1,1,7, 0,0,0,1,3); add(1,1,9, 0,0,0,1,3); add(1,0,0, 1,1,1,1,9);
    for (int i = 0; i < 3; i++) add(1,0,0, 1,0,0,1,9);
    for (int i = 0; i < 5; i++) add(1,0,0, 0,0,0,1,9);
    add(1,0,0, 1,1,0,1,9);

    reset_in = 1'b1;
    enable_in = 1'b0;
    div_load_in = 1'b0;
    div_in = '0;
    repeat (2) @(posedge clk);
    #1 reset_in = 1'b0;
    model_reset();
    check_all("reset", 0, 0, 0, 0, 4);

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].ld, tbl[i].din);
      check_all($sformatf("vec%0d", i), tbl[i].clk, tbl[i].tick, tbl[i].ack, tbl[i].err, tbl[i].act);
    end

    // async reset with a pending ratio
    step(1, 1, 6);
    div_load_in = 1'b0;
    #2 reset_in = 1'b1;
    #1;
    cmp("areset.clk", 32'(clk_div_out), 0);
    cmp("areset.tick", 32'(tick_out), 0);
    cmp("areset.err", 32'(div_err_out), 0);
    cmp("areset.act", 32'(div_active_out), 4);
    enable_in = 1'b0;
    @(posedge clk);
    #1 reset_in = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      model_step(0, 0, 0);
      check_all($sformatf("postrst%0d", i), e_clk, e_tick, e_ack, m_err, div_t'(m_n));
    end

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bit en, ld;
      int d;
      en = $urandom_range(0, 15) != 0;
      ld = $urandom_range(0, 9) == 0;
      d = (i < 300 && $urandom_range(0, 7) != 0) ? $urandom_range(2, 12) : $urandom_range(0, 12);
      step(en, ld, div_t'(d));
      model_step(en, ld, d);
      check_all($sformatf("rnd%0d", i), e_clk, e_tick, e_ack, m_err, div_t'(m_n));
    end

`ifdef CLKDIV_HALF_CYCLE_EN
    begin
      realtime tr, tf;
      logic prev;
      reset_in = 1'b1;
      #1 reset_in = 1'b0;
      step(0, 1, 5);
      step(0, 0, 0);
      cmp("half.act", 32'(div_active_out), 5);
      enable_in = 1'b1;
      #0.5;
      prev = clk_div_out;
      tr = -1.0;
      tf = -1.0;
      for (int i = 0; i < 400; i++) begin
        #1;
        if (clk_div_out && !prev && tr < 0) tr = $realtime;
        if (!clk_div_out && prev && tr >= 0) begin
          tf = $realtime;
          break;
        end
        prev = clk_div_out;
      end
      n_vec++;
      if (tr < 0 || tf < 0 || (tf - tr) < 24.9 || (tf - tr) > 25.1) begin
        n_err++;
        $display("FAIL half.high_time: got %0f ns expected 25 ns", (tr < 0 || tf < 0) ? -1.0 : tf - tr);
      end
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
